// File: rtl/mem_access_ctrl.sv
// Slot-1 data-memory access controller: drives an addr_ok/data_ok SRAM-like bus,
// builds byte strobes / lane-shifted store data and stalls until completion.
// Optional misalignment detection is compiled in with ADDR_CHECK_EN.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        adel_o,
  output logic        ades_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LWL_OP = 8'b1110_0010;
  localparam logic [7:0] EXE_LWR_OP = 8'b1110_0110;
  localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_SWL_OP = 8'b1110_1010;
  localparam logic [7:0] EXE_SWR_OP = 8'b1110_1110;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CANCEL, DONE} state_t;

  // Valid/ready: a request is held on the bus (data_req=1, fields frozen) until
  // data_addr_ok; the response arrives when data_data_ok is high, possibly the same cycle.
  state_t state, state_next;

  logic [1:0]  a;
  logic        is_load, is_store;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        mis_load, mis_store, start;

  assign a = mem_addr_i[1:0];

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    req_size  = 2'd2;
    req_addr  = mem_addr_i;
    req_wstrb = 4'b0000;
    req_wdata = 32'h0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: begin
        is_load  = 1'b1;
        req_size = 2'd0;
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        is_load  = 1'b1;
        req_size = 2'd1;
      end
      EXE_LW_OP, EXE_LL_OP: is_load = 1'b1;
      EXE_LWL_OP, EXE_LWR_OP: begin
        is_load  = 1'b1;
        req_addr = {mem_addr_i[31:2], 2'b00};
      end
      EXE_SB_OP: begin
        is_store  = 1'b1;
        req_size  = 2'd0;
        req_wstrb = 4'b0001 << a;
        req_wdata = {4{reg2_i[7:0]}};
      end
      EXE_SH_OP: begin
        is_store  = 1'b1;
        req_size  = 2'd1;
        req_wstrb = a[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{reg2_i[15:0]}};
      end
      EXE_SW_OP: begin
        is_store  = 1'b1;
        req_wstrb = 4'b1111;
        req_wdata = reg2_i;
      end
      EXE_SWL_OP: begin
        is_store  = 1'b1;
        req_addr  = {mem_addr_i[31:2], 2'b00};
        req_wstrb = 4'b1111 >> (2'd3 - a);
        req_wdata = reg2_i >> {2'd3 - a, 3'b000};
      end
      EXE_SWR_OP: begin
        is_store  = 1'b1;
        req_addr  = {mem_addr_i[31:2], 2'b00};
        req_wstrb = 4'b1111 << a;
        req_wdata = reg2_i << {a, 3'b000};
      end
      default: ;
    endcase
  end

`ifdef ADDR_CHECK_EN
  assign mis_load  = valid_i & ((((aluop_i == EXE_LH_OP) | (aluop_i == EXE_LHU_OP)) & a[0]) |
                                (((aluop_i == EXE_LW_OP) | (aluop_i == EXE_LL_OP)) & (a != 2'd0)));
  assign mis_store = valid_i & (((aluop_i == EXE_SH_OP) & a[0]) |
                                ((aluop_i == EXE_SW_OP) & (a != 2'd0)));
`else
  assign mis_load  = 1'b0;
  assign mis_store = 1'b0;
`endif

  assign start = valid_i & (is_load | is_store) & ~flush_i & ~mis_load & ~mis_store;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = REQ;
      REQ: begin
        if (data_addr_ok && data_data_ok) state_next = DONE;
        else if (data_addr_ok)            state_next = WAIT;
        else if (flush_i)                 state_next = IDLE;
      end
      WAIT: begin
        if (data_data_ok) state_next = DONE;
        else if (flush_i) state_next = CANCEL;
      end
      CANCEL: if (data_data_ok) state_next = IDLE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // DONE drops the stall so the ex/mem register advances; DONE always returns to IDLE.
  always_comb begin
    data_req   = (state == REQ);
    stallreq_o = ((state == IDLE) & start) | (state == REQ) | (state == WAIT) | (state == CANCEL);
    adel_o     = (state == IDLE) & mis_load;
    ades_o     = (state == IDLE) & mis_store;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'h0;
      data_wstrb <= 4'b0000;
      data_wdata <= 32'h0;
    end else if (state == IDLE && start) begin
      data_wr    <= is_store;
      data_size  <= req_size;
      data_addr  <= req_addr;
      data_wstrb <= req_wstrb;
      data_wdata <= req_wdata;
    end
  end

  // Responses landing in CANCEL belong to a flushed access and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_data_o <= 32'h0;
    end else if (!data_wr && (((state == REQ) && data_addr_ok && data_data_ok) ||
                              ((state == WAIT) && data_data_ok))) begin
      mem_data_o <= data_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; define ADDR_CHECK_EN to build the
// misalignment-detect variant of the checks.
module tb_mem_access_ctrl;

  localparam logic [7:0] EXE_NOP_OP = 8'h00;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LWL_OP = 8'b1110_0010;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_SWL_OP = 8'b1110_1010;
  localparam logic [7:0] EXE_SWR_OP = 8'b1110_1110;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, flush_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] mem_data_o;
  logic        stallreq_o, adel_o, ades_o;

  logic [70:0] req_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] last_rd;
  int          n_checks = 0;
  int          n_errors = 0;
  int          stall_cnt;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .mem_data_o(mem_data_o), .stallreq_o(stallreq_o),
    .adel_o(adel_o), .ades_o(ades_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample the stall just before the edge (inputs settled), then step one cycle.
  task automatic tick();
    @(negedge clk);
    stall_cnt += int'(stallreq_o);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_req(input string tag);
    logic [70:0] obs;
    obs = {data_wr, data_size, data_addr, data_wstrb, data_wr ? data_wdata : 32'h0};
    if (req_q.size() == 0) chk({tag, "_q_empty"}, 1, 0);
    else chk(tag, obs, req_q.pop_front());
  endtask

  task automatic pop_rd(input string tag);
    if (rd_q.size() == 0) chk({tag, "_q_empty"}, 1, 0);
    else begin
      last_rd = rd_q.pop_front();
      chk(tag, mem_data_o, last_rd);
    end
  endtask

  task automatic drive_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = r2;
  endtask

  // Access where the bus answers addr_ok and data_ok in the first REQ cycle.
  task automatic do_fast(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] r2, input logic exp_wr, input logic [1:0] exp_size,
                         input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata, input logic [31:0] rdata);
    drive_op(op, addr, r2);
    req_q.push_back({exp_wr, exp_size, exp_addr, exp_strb, exp_wr ? exp_wdata : 32'h0});
    if (!exp_wr) rd_q.push_back(rdata);
    #1 chk({tag, "_idle_stall"}, stallreq_o, 1);
    tick();
    chk({tag, "_req"}, data_req, 1);
    pop_req({tag, "_fields"});
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = rdata;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; valid_i = 1'b0; data_rdata = $urandom;
    #1 chk({tag, "_done_stall"}, stallreq_o, 0);
    chk({tag, "_done_req"}, data_req, 0);
    if (!exp_wr) pop_rd({tag, "_rdata"});
    else chk({tag, "_rdata_kept"}, mem_data_o, last_rd);
    tick();
    chk({tag, "_idle_req"}, data_req, 0);
  endtask

  task automatic chk_all_reset(input string tag);
    chk(tag, {data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, mem_data_o,
              stallreq_o, adel_o, ades_o}, 0);
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0; aluop_i = EXE_NOP_OP;
    mem_addr_i = 32'h0; reg2_i = 32'h0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = 32'h0; last_rd = 32'h0; stall_cnt = 0;
    #12 chk_all_reset("reset_values");
    rst = 1'b1;
    tick();

    // LW: addr_ok in REQ, data_ok two cycles later in WAIT
    stall_cnt = 0;
    drive_op(EXE_LW_OP, 32'h1000_0004, 32'h0);
    req_q.push_back({1'b0, 2'd2, 32'h1000_0004, 4'b0000, 32'h0});
    tick();
    chk("lw_req", data_req, 1);
    pop_req("lw_fields");
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    chk("lw_wait_req", data_req, 0);
    tick();
    chk("lw_wait_stall", stallreq_o, 1);
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    rd_q.push_back(32'hDEAD_BEEF);
    tick();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    #1 chk("lw_done_stall", stallreq_o, 0);
    pop_rd("lw_rdata");
    tick();
    chk("lw_stall_cycles", stall_cnt, 4);
    chk("lw_no_reissue", data_req, 0);
    valid_i = 1'b0;
    tick();
    chk("lw_idle_req", data_req, 0);

    do_fast("sb", EXE_SB_OP, 32'h2000_0003, 32'h1234_5678, 1, 2'd0, 32'h2000_0003, 4'b1000, 32'h7878_7878, 32'h0);
    do_fast("swl1", EXE_SWL_OP, 32'h2000_0001, 32'hAABB_CCDD, 1, 2'd2, 32'h2000_0000, 4'b0011, 32'h0000_AABB, 32'h0);
    do_fast("swr1", EXE_SWR_OP, 32'h2000_0001, 32'hAABB_CCDD, 1, 2'd2, 32'h2000_0000, 4'b1110, 32'hBBCC_DD00, 32'h0);
    do_fast("swl0", EXE_SWL_OP, 32'h2000_0010, 32'hAABB_CCDD, 1, 2'd2, 32'h2000_0010, 4'b0001, 32'h0000_00AA, 32'h0);
    do_fast("swl3", EXE_SWL_OP, 32'h2000_0013, 32'hAABB_CCDD, 1, 2'd2, 32'h2000_0010, 4'b1111, 32'hAABB_CCDD, 32'h0);
    do_fast("swr3", EXE_SWR_OP, 32'h2000_0013, 32'hAABB_CCDD, 1, 2'd2, 32'h2000_0010, 4'b1000, 32'hDD00_0000, 32'h0);
    do_fast("sh2", EXE_SH_OP, 32'h2000_0002, 32'h0000_BEEF, 1, 2'd1, 32'h2000_0002, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    do_fast("sb0", EXE_SB_OP, 32'h2000_0000, 32'h0000_00A5, 1, 2'd0, 32'h2000_0000, 4'b0001, 32'hA5A5_A5A5, 32'h0);
    do_fast("lb", EXE_LB_OP, 32'h3000_0001, 32'h0, 0, 2'd0, 32'h3000_0001, 4'b0000, 32'h0, 32'h1122_3344);
    do_fast("lwl", EXE_LWL_OP, 32'h3000_0003, 32'h0, 0, 2'd2, 32'h3000_0000, 4'b0000, 32'h0, 32'hCAFE_F00D);

    // Non-memory op: neither stall nor request
    drive_op(EXE_NOP_OP, 32'h3000_0000, 32'h0);
    #1 chk("nop_stall", stallreq_o, 0);
    tick();
    chk("nop_req", data_req, 0);
    valid_i = 1'b0;

    // Flush while in REQ withdraws the request
    drive_op(EXE_LW_OP, 32'h1000_0010, 32'h0);
    req_q.push_back({1'b0, 2'd2, 32'h1000_0010, 4'b0000, 32'h0});
    tick();
    pop_req("flushreq_fields");
    flush_i = 1'b1; valid_i = 1'b0;
    tick();
    flush_i = 1'b0;
    chk("flushreq_req", data_req, 0);
    #1 chk("flushreq_stall", stallreq_o, 0);

    // Flush in WAIT: CANCEL discards the late response
    drive_op(EXE_LW_OP, 32'h1000_0008, 32'h0);
    req_q.push_back({1'b0, 2'd2, 32'h1000_0008, 4'b0000, 32'h0});
    tick();
    pop_req("cancel_fields");
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    #1 chk("cancel_stall0", stallreq_o, 1);
    tick();
    chk("cancel_stall1", stallreq_o, 1);
    data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    tick();
    data_data_ok = 1'b0;
    #1 chk("cancel_idle_stall", stallreq_o, 0);
    chk("cancel_rdata_kept", mem_data_o, last_rd);
    tick();
    chk("cancel_idle_req", data_req, 0);

`ifdef ADDR_CHECK_EN
    drive_op(EXE_LH_OP, 32'h4000_0001, 32'h0);
    #1 chk("lh_mis_adel", adel_o, 1);
    chk("lh_mis_stall", stallreq_o, 0);
    tick();
    chk("lh_mis_req", data_req, 0);
    drive_op(EXE_SW_OP, 32'h4000_0002, 32'h0);
    #1 chk("sw_mis_ades", ades_o, 1);
    chk("sw_mis_adel", adel_o, 0);
    tick();
    chk("sw_mis_req", data_req, 0);
    valid_i = 1'b0;
    tick();
`else
    drive_op(EXE_LH_OP, 32'h4000_0001, 32'h0);
    #1 chk("lh_mis_adel", adel_o, 0);
    do_fast("lh_mis", EXE_LH_OP, 32'h4000_0001, 32'h0, 0, 2'd1, 32'h4000_0001, 4'b0000, 32'h0, 32'h0BAD_F00D);
`endif

    // Asynchronous reset while in WAIT
    drive_op(EXE_SW_OP, 32'h5000_0000, 32'h0102_0304);
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; valid_i = 1'b0;
    chk("rst_wait_stall", stallreq_o, 1);
    #2 rst = 1'b0;
    #1 chk_all_reset("rst_in_wait");
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("rst_after_req", data_req, 0);
    chk("sb_queue_drained", req_q.size() + rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Data-memory access controller between the execute stage and the `mem` stage of the dual-issue MIPS pipeline. It takes the slot-1 memory operation (aluop, effective address, store operand), drives an SRAM-like data bus with an addr_ok/data_ok handshake, and generates byte strobes and lane-shifted store data, including SWL/SWR. It returns the raw loaded word to the `mem` stage for lane extraction and holds the pipeline stalled until the access completes.

## Interface
No parameters. Widths come from `defines.v`: RegBus = 32, AluOpBus = 8.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- valid_i  in  1  the ex/mem slot-1 operation is valid
- flush_i  in  1  pipeline flush (exception or eret)
- aluop_i  in  AluOpBus  slot-1 operation code
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store operand
- data_req  out  1  bus request
- data_wr  out  1  1 = store, 0 = load
- data_size  out  2  bus size: 0 = byte, 1 = half, 2 = word
- data_addr  out  32  bus address
- data_wstrb  out  4  byte-lane write strobes
- data_wdata  out  32  lane-positioned store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response valid
- data_rdata  in  32  load data
- mem_data_o  out  32  registered load word, fed to `mem` as mem_data_i
- stallreq_o  out  1  stall request to the pipeline controller
- adel_o  out  1  load address error (see Configuration)
- ades_o  out  1  store address error (see Configuration)

## Operation
- Memory operations:
  - Loads: `EXE_LB/LBU/LH/LHU/LW/LWL/LWR/LL_OP`.
  - Stores: `EXE_SB/SH/SW/SWL/SWR_OP`.
  - Any other aluop: no access and no stall.
- Let a = mem_addr_i[1:0].
- data_addr:
  - LWL, LWR, SWL, SWR: {mem_addr_i[31:2], 2'b00}, with data_size = 2.
  - All other operations: mem_addr_i unchanged.
- Store strobes and data:
  - SB: strobe 4'b0001 << a; data {4{reg2[7:0]}}.
  - SH: strobe 0011 (a = 0) or 1100 (a = 2); data {2{reg2[15:0]}}.
  - SW: strobe 1111; data reg2.
  - SWL, a = 0/1/2/3: strobe 0001/0011/0111/1111; data = reg2 >> (8 × (3 − a)).
  - SWR, a = 0/1/2/3: strobe 1111/1110/1100/1000; data = reg2 << (8 × a).
  - Loads: strobe 0000.
- FSM states: IDLE, REQ, WAIT, CANCEL, DONE. All state is registered.
  - IDLE: a valid memory operation with no flush and no address error goes to REQ.
  - REQ: data_req = 1, and the request fields are held stable.
    - addr_ok with data_ok in the same cycle goes to DONE.
    - addr_ok alone goes to WAIT.
    - flush_i with no addr_ok goes to IDLE (request withdrawn).
  - WAIT: data_ok goes to DONE. flush_i with no data_ok goes to CANCEL.
  - CANCEL: waits for data_ok, discards the response, then goes to IDLE.
  - DONE: one cycle, then IDLE.
- mem_data_o captures data_rdata on data_ok in REQ or WAIT for a load. Stores and CANCEL leave it unchanged.
- stallreq_o = (IDLE & valid memory op & !flush_i & no address error) | REQ | WAIT | CANCEL.
  - It is deasserted in DONE so the ex/mem register advances at the end of DONE.
  - Because DONE always passes through IDLE, the same operation is never reissued.
- A flush in DONE has no effect; the access has already completed.

## Timing
- Reset values:
  - State IDLE.
  - data_req, data_wr, data_wstrb, data_wdata, data_addr, data_size all 0.
  - mem_data_o = 0.
  - stallreq_o, adel_o, ades_o all 0.
- Request fields are registered on entry to REQ and stay constant until addr_ok.
- Minimum access is 3 cycles, IDLE → REQ → DONE, when addr_ok and data_ok arrive in the first REQ cycle. mem_data_o is valid in DONE.
- Reset asserted mid-transaction returns the block to IDLE immediately. The bus is assumed to be reset together with the block.

## Configuration
- `ADDR_CHECK_EN` defined:
  - Misaligned accesses are detected in IDLE while valid_i is high: LH/LHU/SH with addr[0] = 1, or LW/LL/SW with a ≠ 0.
  - adel_o or ades_o is asserted combinationally.
  - No request is issued and no stall is raised.
- `ADDR_CHECK_EN` undefined:
  - adel_o and ades_o are tied to 0.
  - The access is issued with the unmodified address.

## Test plan
- LW at 0x1000_0004, bus answers addr_ok at cycle 1 and data_ok = 1 with rdata = 0xDEAD_BEEF at cycle 3 → stall for 4 cycles, then mem_data_o = 0xDEAD_BEEF in DONE and no second request.
- SB at address ...03, reg2 = 0x1234_5678 → wstrb = 1000, wdata = 0x7878_7878, wr = 1, size = 0.
- SWL at ...01 and SWR at ...01, reg2 = 0xAABB_CCDD → SWL: wstrb 0011, wdata 0x0000_AABB. SWR: wstrb 1110, wdata 0xBBCC_DD00. Both with address word-aligned.
- flush_i asserted in WAIT, then data_ok two cycles later with rdata = 0x5555_5555 → state goes CANCEL then IDLE, mem_data_o unchanged, stallreq_o held until data_ok.
- With `ADDR_CHECK_EN` defined, LH at ...01 → adel_o = 1, data_req stays 0, stallreq_o = 0. Without the macro → request issued with addr ...01.
- Reset driven low while in WAIT → all outputs return to their reset values asynchronously.
